// File: rtl/vpu_pkg.sv
// Shared types and default sizes for the vector memory streamer.
// Default RAM geometry matches dp_ram.
package vpu_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      RD    = 2'd2,
      DRAIN = 2'd3
   } stream_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that absorbs read data returning from the RAM.
// Each entry carries the element plus its end-of-command flag.
module stream_skid_fifo
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [1:0]            count,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   logic [DATA_WIDTH-1:0] data_q [2];
   logic [1:0]            last_q;
   logic                  wr_ptr;
   logic                  rd_ptr;

   // storage, pointers and occupancy; the caller never pushes
   // when full nor pops when empty
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         last_q    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head_data = data_q[rd_ptr];
   assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/vec_mem_streamer.sv
// Strided command sequencer between the vector datapath and dp_ram port A.
// Build option VPU_STREAM_STRIDE_EN: honour cmd_stride, else stride is 1.
module vec_mem_streamer
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_stride,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  busy,
   output logic                  done
);

   stream_state_t         state_q;
   stream_state_t         state_d;
   logic [LEN_WIDTH-1:0]  i_q;
   logic [LEN_WIDTH-1:0]  i_d;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  len_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [ADDR_WIDTH-1:0] step;
   logic                  done_d;
   logic                  done_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  issue;
   logic                  issue_ok;
   logic                  last_elem;
   logic                  pop;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_last;
   logic [2:0]            occ;

`ifdef VPU_STREAM_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [ADDR_WIDTH-1:0] stride_d;

   assign step = stride_q;
`else
   logic unused_stride;

   assign step          = ADDR_WIDTH'(1);
   assign unused_stride = ^cmd_stride;
`endif

   assign last_elem = (i_q == len_q - LEN_WIDTH'(1));

   // a read may issue only if its data will find a free FIFO slot
   assign pop      = rd_valid & rd_ready;
   assign occ      = {1'b0, fifo_count} + {2'b0, inflight_q};
   assign issue_ok = occ < (3'd2 + {2'b0, pop});

   // next-state, counters and port A drive
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      len_d     = len_q;
      addr_d    = addr_q;
      done_d    = 1'b0;
      issue     = 1'b0;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
`ifdef VPU_STREAM_STRIDE_EN
      stride_d  = stride_q;
`endif
      unique case (state_q)
         IDLE: begin
            cmd_ready = ~rst;
            if (cmd_valid && !rst) begin
               len_d  = cmd_len;
               addr_d = cmd_base;
               i_d    = '0;
`ifdef VPU_STREAM_STRIDE_EN
               stride_d = cmd_stride;
`endif
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else if (cmd_write) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         WR: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid;
            ram_addr = addr_q;
            ram_din  = wr_data;
            if (wr_valid) begin
               addr_d = addr_q + step;
               i_d    = i_q + LEN_WIDTH'(1);
               if (last_elem) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RD: begin
            if (issue_ok) begin
               issue    = 1'b1;
               ram_addr = addr_q;
               addr_d   = addr_q + step;
               i_d      = i_q + LEN_WIDTH'(1);
               if (last_elem) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifo_count == 2'd0 && !inflight_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, command registers and the one-deep read pipeline tag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         i_q             <= '0;
         len_q           <= '0;
         addr_q          <= '0;
         done_q          <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         i_q             <= i_d;
         len_q           <= len_d;
         addr_q          <= addr_d;
         done_q          <= done_d;
         inflight_q      <= issue;
         inflight_last_q <= issue & last_elem;
      end
   end

`ifdef VPU_STREAM_STRIDE_EN
   // stride is latched with the command
   always_ff @(posedge clk) begin
      if (rst) begin
         stride_q <= '0;
      end else begin
         stride_q <= stride_d;
      end
   end
`endif

   stream_skid_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_data(ram_dout),
      .push_last(inflight_last_q),
      .pop      (pop),
      .count    (fifo_count),
      .head_data(head_data),
      .head_last(head_last)
   );

   assign rd_valid = (fifo_count != 2'd0);
   assign rd_data  = rd_valid ? head_data : '0;
   assign rd_last  = rd_valid & head_last;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

endmodule

// File: doc/vec_mem_streamer.md
# vec_mem_streamer

Command-driven sequencer that sits directly upstream of `dp_ram` port A and moves vector elements between the RAM and the vector datapath. One command names a strided address pattern and a direction. Writes consume a valid/ready input stream into RAM; reads issue RAM reads and present results on a valid/ready output stream, absorbing the RAM's 1-cycle read latency and any downstream backpressure. Port B of `dp_ram` is left to other agents.

## Interface
- `DATA_WIDTH`, 8, element width; matches `dp_ram`.
- `ADDR_WIDTH`, 6, RAM address width; matches `dp_ram`.
- `LEN_WIDTH`, `ADDR_WIDTH+1`, element-count width; max length is 2^ADDR_WIDTH.

- `clk` in 1, single clock; everything is rising-edge.
- `rst` in 1, synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1, command handshake.
- `cmd_write` in 1, 1 = stream into RAM, 0 = stream out of RAM.
- `cmd_base` in ADDR_WIDTH, first element address.
- `cmd_stride` in ADDR_WIDTH, address increment per element.
- `cmd_len` in LEN_WIDTH, element count.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DATA_WIDTH, write stream.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out DATA_WIDTH / `rd_last` out 1, read stream.
- `ram_we` out 1 / `ram_addr` out ADDR_WIDTH / `ram_din` out DATA_WIDTH, drive `dp_ram` port A.
- `ram_dout` in DATA_WIDTH, port A read data.
- `busy` out 1, high whenever the state is not IDLE.
- `done` out 1, one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, WR, RD, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On handshake, latch base/stride/len and clear the element counter `i`.
  - Go to WR or RD. If `cmd_len`=0, stay in IDLE, pulse `done` next cycle, and make no RAM access.
- Address rule: element address = `cmd_base + i*cmd_stride` mod 2^ADDR_WIDTH. Wrap-around is silent. It is computed as a running accumulator, not a multiply.
- WR:
  - `wr_ready`=1.
  - `ram_we`=`wr_valid` (combinational), with `ram_addr`=current address and `ram_din`=`wr_data`.
  - Each beat increments `i`. After beat `len-1`, return to IDLE and pulse `done`.
- RD:
  - `ram_we`=0.
  - Issue a read (drive `ram_addr` and advance `i`) only when `fifo_count + inflight - pop < 2`. Here `pop` = `rd_valid & rd_ready` in the same cycle.
  - `inflight` is 1 for the cycle after an issue. `ram_dout` is then captured into a 2-entry FIFO.
  - After the last issue, go to DRAIN.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then go to IDLE and pulse `done`.
- `rd_last` is high on the FIFO head that is element `len-1`.
- `rd_data`/`rd_valid` come from the FIFO head. They must hold stable while `rd_valid & !rd_ready`.
- Outside WR, `wr_ready`=0. Outside RD/DRAIN, `rd_valid`=0. `ram_we` is never high outside WR.

## Timing
- Reset values:
  - `cmd_ready`, `wr_ready`, `rd_valid`, `rd_last`, `ram_we`, `busy`, `done` = 0.
  - `ram_addr`, `ram_din`, `rd_data` = 0.
  - FIFO is empty; `inflight` = 0.
  - `cmd_ready` rises in the first cycle after `rst` deasserts.
- Read latency: command handshake in cycle N → first `ram_addr` in N+1 → `ram_dout` sampled in N+2 → `rd_valid` in N+3.
- Read throughput: with `rd_ready` held high, one element per cycle.
- Write latency: a write beat accepted in cycle N is written by `dp_ram` at the N/N+1 edge.
- Write throughput: one element per cycle.
- `done` is asserted in the cycle the FSM re-enters IDLE.
- A new command may be accepted in the same cycle `done` is high.
- `rst` mid-command: next cycle is IDLE. FIFO is flushed, the in-flight read is discarded, and no `done` pulse is produced.

## Configuration
- `VPU_STREAM_STRIDE_EN` defined: `cmd_stride` is honoured as above.
- Undefined: stride is fixed to 1. `cmd_stride` stays on the port list but is ignored, and the stride register and adder input are removed.

## Structure
- `vpu_pkg` holds:
  - `stream_state_t` (IDLE/WR/RD/DRAIN enum).
  - Default `DATA_WIDTH`/`ADDR_WIDTH` localparams shared with `dp_ram`.
- One sub-module, `stream_skid_fifo`: a 2-entry FIFO with push, pop, count, head data, and head-last flag.

## Test plan
- Write, len=4, base=0x01, stride=1, data AA,BB,CC,DD → RAM[1..4]=AA..DD; `done` after beat 4; readback via port B matches.
- Read, len=4, base=0x01, stride=1, `rd_ready`=1 → `rd_valid` at N+3; AA,BB,CC,DD on consecutive cycles; `rd_last` on DD.
- Read, len=3, base=0x3E, stride=2 (STRIDE_EN) → addresses 0x3E, 0x00, 0x02 (wrap); data in order.
- Read, len=8, `rd_ready` toggled 1,0,0,1,… → no loss or duplication; `rd_data` stable while stalled; FIFO never exceeds 2.
- `cmd_len`=0 → no `ram_we`/`ram_addr` activity; `done` next cycle; `busy` stays 0.
- Assert `rst` during read element 2 of 6 → next cycle IDLE, `rd_valid`=0, no `done`; a following read of len=2 returns correct data.
